sensor_mux_sequencer: RTL and testbench
=======================================

Name: sensor_mux_sequencer

Overview:
Sequences the shared 2:1 SIZE-bit sensor multiplexer. It drives the select line to read sensor A, then sensor B, with a settle delay before each capture. It compares the two readings against a deadband and issues a one-cycle step command that moves a saturating panel-angle register. It sits between the sensor mux and the panel actuator drive, and supports single-shot or continuous scan.

Parameters:
SIZE, 4, width of each sensor reading and of the mux output
SETTLE_CYCLES, 2, cycles the select is held before capture (must be >= 1)
DEADBAND, 1, minimum |A-B| difference that is strictly exceeded before a step is issued
ANGLE_W, 6, width of the angle register
ANGLE_INIT, 32, angle value loaded on reset
ANGLE_MAX, 63, upper angle limit (lower limit is 0)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  starts one scan when sampled high in IDLE; ignored otherwise
cont  in  1  when high at DECIDE, the next scan begins immediately
mux_f  in  SIZE  mux output, =A when mux_sel=0, =B when mux_sel=1
mux_sel  out  1  registered select driven to the mux
sample_a  out  SIZE  last captured A reading
sample_b  out  SIZE  last captured B reading
valid  out  1  one-cycle pulse: samples, step flags and angle are updated
step_up  out  1  one-cycle pulse with valid: angle incremented
step_down  out  1  one-cycle pulse with valid: angle decremented
angle  out  ANGLE_W  current panel angle
at_limit  out  1  high while angle==0 or angle==ANGLE_MAX
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst high at an edge): state=IDLE, mux_sel=0, sample_a=sample_b=0, valid=step_up=step_down=0, busy=0, cnt=0, angle=ANGLE_INIT. at_limit follows angle. Reset has priority over every other input and aborts any scan mid-operation; no valid is issued for the aborted scan.
- States: IDLE, SEL_A, SEL_B, DECIDE. All outputs are registered.
- IDLE: mux_sel=0. If start=1 at edge e0, next state is SEL_A, cnt=0, busy=1.
- SEL_A: mux_sel=0 and cnt increments each cycle. At the edge where cnt==SETTLE_CYCLES-1: sample_a<=mux_f, mux_sel<=1, cnt<=0, next state is SEL_B. The capture occurs at edge e0+SETTLE_CYCLES.
- SEL_B: mux_sel=1 and cnt counts the same way. At the edge where cnt==SETTLE_CYCLES-1: sample_b<=mux_f, mux_sel<=0, next state is DECIDE. The capture occurs at edge e0+2*SETTLE_CYCLES.
- DECIDE lasts one cycle. At its closing edge (e0+2*SETTLE_CYCLES+1):
  - valid<=1.
  - Compare in SIZE+1-bit unsigned arithmetic, with no wrap.
  - If sample_a > sample_b+DEADBAND and angle<ANGLE_MAX: step_up<=1, angle<=angle+1.
  - Else if sample_b > sample_a+DEADBAND and angle>0: step_down<=1, angle<=angle-1.
  - Otherwise no step and angle holds. At a limit the step is suppressed (no pulse) and angle holds.
  - Next state is SEL_A (cnt=0, busy stays 1) if cont=1, else IDLE (busy<=0).
- Latency from start sampled to valid high: 2*SETTLE_CYCLES+1 cycles. Continuous scan period is 2*SETTLE_CYCLES+1 cycles.
- valid, step_up and step_down are high for exactly one cycle. step_up and step_down are never both high.
- start while busy is ignored, not queued. cont is sampled only in DECIDE. Dropping cont mid-scan completes the current scan, then the block returns to IDLE.
- sample_a and sample_b hold their values between scans.

Test Plan:
(SIZE=4, SETTLE_CYCLES=2, DEADBAND=1, ANGLE_INIT=32; the bench models the mux as mux_f = mux_sel ? B : A.)
1. Reset: hold rst for 2 cycles -> mux_sel=0, busy=0, valid=0, step_up=step_down=0, sample_a=sample_b=0, angle=32, at_limit=0.
2. A=9, B=3, start pulse -> mux_sel=0 for 2 cycles, then 1 for 2 cycles; valid high 5 cycles after start; sample_a=9, sample_b=3, step_up=1, angle=33, busy falls with valid.
3. Deadband and step_down:
   - A=5, B=6 -> valid, no step, angle unchanged.
   - Then A=4, B=6 -> step_down=1, angle decremented by 1.
4. Saturation: cont=1, A=15, B=0 from angle=32 -> valid every 5 cycles; angle reaches 63 after 31 decisions; further decisions give valid=1, step_up=0, angle=63, at_limit=1.
5. Busy and abort:
   - A start pulse during SEL_B is ignored (single valid only).
   - rst asserted during SEL_B -> next cycle mux_sel=0, busy=0, samples=0, angle=32, no valid.
6. Cont release: cont deasserted mid-scan -> the current scan completes with valid, then the block enters IDLE with busy=0 and no further valid.

Source files
------------

// File: rtl/sensor_mux_if.sv
// Signal bundle between the sensor-mux sequencer and its mux/actuator-side client.
// The master drives the scan controls and the mux output; the slave is the sequencer.
interface sensor_mux_if #(
    parameter int SIZE    = 4,
    parameter int ANGLE_W = 6
);
    logic               start;
    logic               cont;
    logic [SIZE-1:0]    mux_f;
    logic               mux_sel;
    logic [SIZE-1:0]    sample_a;
    logic [SIZE-1:0]    sample_b;
    logic               valid;
    logic               step_up;
    logic               step_down;
    logic [ANGLE_W-1:0] angle;
    logic               at_limit;
    logic               busy;

    modport master (
        output start, cont, mux_f,
        input  mux_sel, sample_a, sample_b, valid, step_up, step_down,
               angle, at_limit, busy
    );

    modport slave (
        input  start, cont, mux_f,
        output mux_sel, sample_a, sample_b, valid, step_up, step_down,
               angle, at_limit, busy
    );
endinterface

// File: rtl/sensor_mux_sequencer.sv
// Reads sensor A then sensor B through a shared 2:1 mux, compares them against a
// deadband and steps a saturating panel-angle register by one count per decision.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start, select parked on A
// ST_SEL_A  | select on A, settle timer running, capture A at terminal count
// ST_SEL_B  | select on B, settle timer running, capture B at terminal count
// ST_DECIDE | one cycle: compare, step angle, pulse valid, rescan or idle
module sensor_mux_sequencer #(
    parameter int SIZE          = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int DEADBAND      = 1,
    parameter int ANGLE_W       = 6,
    parameter int ANGLE_INIT    = 32,
    parameter int ANGLE_MAX     = 63
) (
    input logic         clk,
    input logic         rst,
    sensor_mux_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEL_A  = 2'd1;
    localparam logic [1:0] ST_SEL_B  = 2'd2;
    localparam logic [1:0] ST_DECIDE = 2'd3;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SIZE:0]      DB       = (SIZE + 1)'(DEADBAND);
    localparam logic [ANGLE_W-1:0] A_INIT   = ANGLE_W'(ANGLE_INIT);
    localparam logic [ANGLE_W-1:0] A_MAX    = ANGLE_W'(ANGLE_MAX);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               mux_sel_q;
    logic [SIZE-1:0]    sample_a_q;
    logic [SIZE-1:0]    sample_b_q;
    logic               valid_q;
    logic               step_up_q;
    logic               step_down_q;
    logic [ANGLE_W-1:0] angle_q;
    logic               busy_q;

    // Widen by one bit so adding the deadband can never wrap.
    logic [SIZE:0] a_ext;
    logic [SIZE:0] b_ext;
    logic          up_req;
    logic          dn_req;

    assign a_ext  = {1'b0, sample_a_q};
    assign b_ext  = {1'b0, sample_b_q};
    assign up_req = a_ext > (b_ext + DB);
    assign dn_req = b_ext > (a_ext + DB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mux_sel_q   <= 1'b0;
            sample_a_q  <= '0;
            sample_b_q  <= '0;
            valid_q     <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            angle_q     <= A_INIT;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mux_sel_q <= 1'b0;
                    if (bus.start) begin
                        state  <= ST_SEL_A;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                ST_SEL_A: begin
                    if (cnt == '0) begin
                        sample_a_q <= bus.mux_f;
                        mux_sel_q  <= 1'b1;
                        cnt        <= CNT_LOAD;
                        state      <= ST_SEL_B;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SEL_B: begin
                    if (cnt == '0) begin
                        sample_b_q <= bus.mux_f;
                        mux_sel_q  <= 1'b0;
                        state      <= ST_DECIDE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DECIDE: begin
                    valid_q <= 1'b1;
                    if (up_req && (angle_q != A_MAX)) begin
                        step_up_q <= 1'b1;
                        angle_q   <= angle_q + 1'b1;
                    end else if (dn_req && (angle_q != '0)) begin
                        step_down_q <= 1'b1;
                        angle_q     <= angle_q - 1'b1;
                    end
                    if (bus.cont) begin
                        state <= ST_SEL_A;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mux_sel   = mux_sel_q;
    assign bus.sample_a  = sample_a_q;
    assign bus.sample_b  = sample_b_q;
    assign bus.valid     = valid_q;
    assign bus.step_up   = step_up_q;
    assign bus.step_down = step_down_q;
    assign bus.angle     = angle_q;
    assign bus.at_limit  = (angle_q == '0) || (angle_q == A_MAX);
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sensor_mux_sequencer.sv
// Scoreboard bench for sensor_mux_sequencer: stimulus queues expected decisions,
// a negedge monitor pops and compares them whenever valid is presented.
module tb_sensor_mux_sequencer;
    logic clk;
    logic rst;
    logic [3:0] a_val;
    logic [3:0] b_val;

    sensor_mux_if #(.SIZE(4), .ANGLE_W(6)) bus ();

    sensor_mux_sequencer #(
        .SIZE(4), .SETTLE_CYCLES(2), .DEADBAND(1),
        .ANGLE_W(6), .ANGLE_INIT(32), .ANGLE_MAX(63)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mux_f = bus.mux_sel ? b_val : a_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] sa;
        logic [3:0] sb;
        logic       up;
        logic       dn;
        logic [5:0] ang;
        logic       busy;
        logic       lim;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;
    int n_valid  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int cyc, input logic [3:0] sa, input logic [3:0] sb,
                        input logic up, input logic dn, input logic [5:0] ang,
                        input logic busy, input logic lim);
        exp_t e;
        e.cyc = cyc; e.sa = sa; e.sb = sb; e.up = up; e.dn = dn;
        e.ang = ang; e.busy = busy; e.lim = lim;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (bus.valid) begin
            n_valid++;
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(bus.valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_cycle", 32'(ncyc),          32'(e.cyc));
                chk("sample_a",    32'(bus.sample_a),  32'(e.sa));
                chk("sample_b",    32'(bus.sample_b),  32'(e.sb));
                chk("step_up",     32'(bus.step_up),   32'(e.up));
                chk("step_down",   32'(bus.step_down), 32'(e.dn));
                chk("angle",       32'(bus.angle),     32'(e.ang));
                chk("busy",        32'(bus.busy),      32'(e.busy));
                chk("at_limit",    32'(bus.at_limit),  32'(e.lim));
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b, output int t0);
        @(negedge clk); #1;
        a_val = a;
        b_val = b;
        bus.start = 1'b1;
        t0 = ncyc;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valids(input int target, input int budget);
        int n;
        n = 0;
        while (n_valid < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (n_valid < target) chk("valid_timeout", 32'(n_valid), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int t0;
        int nv;
        logic [5:0] ang;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        a_val = 4'd0;
        b_val = 4'd0;

        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_mux_sel",   32'(bus.mux_sel),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_valid",     32'(bus.valid),     32'd0);
        chk("rst_step_up",   32'(bus.step_up),   32'd0);
        chk("rst_step_down", 32'(bus.step_down), 32'd0);
        chk("rst_sample_a",  32'(bus.sample_a),  32'd0);
        chk("rst_sample_b",  32'(bus.sample_b),  32'd0);
        chk("rst_angle",     32'(bus.angle),     32'd32);
        chk("rst_at_limit",  32'(bus.at_limit),  32'd0);
        rst = 1'b0;

        // 2: A=9 B=3 -> step up to 33, select sequence 0,0,1,1,0
        issue(4'd9, 4'd3, t0);
        push(t0 + 6, 4'd9, 4'd3, 1'b1, 1'b0, 6'd33, 1'b0, 1'b0);
        chk("sel_c1", 32'(bus.mux_sel), 32'd0);
        chk("busy_c1", 32'(bus.busy), 32'd1);
        @(negedge clk); #1; chk("sel_c2", 32'(bus.mux_sel), 32'd0);
        @(negedge clk); #1; chk("sel_c3", 32'(bus.mux_sel), 32'd1);
        @(negedge clk); #1; chk("sel_c4", 32'(bus.mux_sel), 32'd1);
        @(negedge clk); #1; chk("sel_c5", 32'(bus.mux_sel), 32'd0);
        wait_valids(1, 20);
        idle_cycles(2);

        // 3: inside deadband, then step down
        issue(4'd5, 4'd6, t0);
        push(t0 + 6, 4'd5, 4'd6, 1'b0, 1'b0, 6'd33, 1'b0, 1'b0);
        wait_valids(2, 20);
        idle_cycles(2);
        issue(4'd4, 4'd6, t0);
        push(t0 + 6, 4'd4, 4'd6, 1'b0, 1'b1, 6'd32, 1'b0, 1'b0);
        wait_valids(3, 20);
        idle_cycles(2);

        // 4 + 6: continuous scan to saturation, cont dropped mid-scan
        bus.cont = 1'b1;
        issue(4'd15, 4'd0, t0);
        for (int k = 0; k < 34; k++) begin
            ang = (k < 31) ? 6'(33 + k) : 6'd63;
            push(t0 + 6 + 5 * k, 4'd15, 4'd0, (k < 31), 1'b0, ang, (k < 33), (ang == 6'd63));
        end
        wait_valids(3 + 33, 400);
        bus.cont = 1'b0;
        wait_valids(3 + 34, 20);
        nv = n_valid;
        idle_cycles(12);
        chk("cont_release_no_valid", 32'(n_valid), 32'(nv));
        chk("cont_release_busy", 32'(bus.busy), 32'd0);

        // 5a: start during SEL_B ignored
        issue(4'd5, 4'd5, t0);
        push(t0 + 6, 4'd5, 4'd5, 1'b0, 1'b0, 6'd63, 1'b0, 1'b1);
        idle_cycles(2);
        bus.start = 1'b1;
        idle_cycles(1);
        bus.start = 1'b0;
        wait_valids(nv + 1, 20);
        nv = n_valid;
        idle_cycles(12);
        chk("ignored_start_no_valid", 32'(n_valid), 32'(nv));
        chk("ignored_start_busy", 32'(bus.busy), 32'd0);

        // 5b: reset during SEL_B aborts the scan
        issue(4'd1, 4'd9, t0);
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(1);
        chk("abort_mux_sel",  32'(bus.mux_sel),  32'd0);
        chk("abort_busy",     32'(bus.busy),     32'd0);
        chk("abort_valid",    32'(bus.valid),    32'd0);
        chk("abort_sample_a", 32'(bus.sample_a), 32'd0);
        chk("abort_sample_b", 32'(bus.sample_b), 32'd0);
        chk("abort_angle",    32'(bus.angle),    32'd32);
        chk("abort_at_limit", 32'(bus.at_limit), 32'd0);
        rst = 1'b0;
        idle_cycles(12);
        chk("abort_no_valid", 32'(n_valid), 32'(nv));
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
